// File: rtl/math_divider_result_bcd.sv
// rtl/math_divider_result_bcd.sv - shift-add-3 binary-to-BCD converter for array divider results
// Optional divide-by-zero short-cut enabled by defining MATH_DIVIDER_DIV0_CHECK_EN.
module math_divider_result_bcd #(
  parameter int xWIDTH = 8,
  parameter int yWIDTH = 4,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [xWIDTH-1:0]   q,
  input  logic [yWIDTH:0]     r,
  input  logic [yWIDTH-1:0]   y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] bcd,
  output logic [yWIDTH:0]     rem,
  output logic                div0
);

  localparam int CW = $clog2(xWIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [xWIDTH-1:0]   sr_q, sr_d;
  logic [BW-1:0]       acc_q, acc_d, acc_adj;
  logic [yWIDTH:0]     rem_q, rem_d;
  logic                div0_q, div0_d;

`ifndef MATH_DIVIDER_DIV0_CHECK_EN
  logic unused_y;
  assign unused_y = ^y;
`endif

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // SHIFT runs one extra cycle with cnt_q == 0 before moving to DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    div0_d  = div0_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_d    = q;
          rem_d   = r;
          acc_d   = '0;
          div0_d  = 1'b0;
          cnt_d   = CW'(xWIDTH);
          state_d = SHIFT;
`ifdef MATH_DIVIDER_DIV0_CHECK_EN
          if (y == '0) begin
            acc_d   = {BW{1'b1}};
            div0_d  = 1'b1;
            cnt_d   = '0;
            state_d = DONE;
          end
`endif
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          {acc_d, sr_d} = {acc_adj[BW-2:0], sr_q, 1'b0};
          cnt_d         = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      div0_q  <= div0_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign bcd       = acc_q;
  assign rem       = rem_q;
`ifdef MATH_DIVIDER_DIV0_CHECK_EN
  assign div0      = div0_q;
`else
  assign div0      = 1'b0;
`endif

endmodule

// File: doc/math_divider_result_bcd.md
MATH_DIVIDER_RESULT_BCD -- requirements
Module: math_divider_result_bcd

Interface
REQ-001 SHALL have parameter xWIDTH, default 8: width of the quotient q produced by the array divider.
REQ-002 SHALL have parameter yWIDTH, default 4: divisor width; remainder width is yWIDTH+1.
REQ-003 SHALL have parameter DIGITS, default 3: number of BCD digits; DIGITS >= ceil(xWIDTH*0.30103).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  q, r and y are valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts a new result this cycle.
REQ-008 SHALL have port q  input  xWIDTH  quotient from the array divider.
REQ-009 SHALL have port r  input  yWIDTH+1  remainder from the array divider.
REQ-010 SHALL have port y  input  yWIDTH  divisor that produced q and r.
REQ-011 SHALL have port out_valid  output  1  bcd, rem and div0 are valid.
REQ-012 SHALL have port out_ready  input  1  downstream consumes the result.
REQ-013 SHALL have port bcd  output  4*DIGITS  packed BCD quotient, digit 0 in bits [3:0].
REQ-014 SHALL have port rem  output  yWIDTH+1  registered copy of r.
REQ-015 SHALL have port div0  output  1  divide-by-zero flag.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-017 In IDLE, in_valid=1 SHALL capture q into the shift register, r into rem, and y, clear the BCD accumulator, load bit counter = xWIDTH, and go to SHIFT.
REQ-018 Each SHIFT cycle SHALL add 3 to every accumulator digit >= 5, then shift {accumulator, shift register} left by one (shift-add-3), and decrement the counter.
REQ-019 When the counter reaches 0 after xWIDTH SHIFT cycles, the FSM SHALL enter DONE; out_valid SHALL rise xWIDTH+1 clock edges after the accept edge (9 for xWIDTH=8).
REQ-020 In DONE, bcd, rem and div0 SHALL hold stable until out_valid&out_ready; on that edge the FSM SHALL return to IDLE.
REQ-021 A new result SHALL NOT be accepted on the DONE->IDLE edge; the earliest next accept is the following edge.
REQ-022 in_valid during SHIFT or DONE SHALL be ignored; q, r and y changes SHALL NOT affect a conversion in progress.
REQ-023 q = 2^xWIDTH-1 SHALL convert exactly; no digit SHALL exceed 9.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, counter=0, bcd=0, rem=0, div0=0, out_valid=0, in_ready=1.
REQ-025 Reset during SHIFT or DONE SHALL abort the conversion with no output; the first accept after release restarts cleanly.

Configuration
REQ-026 With macro MATH_DIVIDER_DIV0_CHECK_EN defined, a captured y==0 SHALL go from IDLE directly to DONE (out_valid on the next edge), set div0=1, bcd all digits 4'hF, and rem=r.
REQ-027 Without MATH_DIVIDER_DIV0_CHECK_EN, y SHALL be ignored, div0 SHALL be constant 0, and y==0 SHALL be converted like any other q.

Verification
REQ-028 Accept q=8'd255, r=0, y=1 -> after 9 edges out_valid=1, bcd=12'h255, rem=0, div0=0.
REQ-029 Accept q=8'd28, r=5'd4, y=4'd7 (x=200) -> bcd=12'h028, rem=4; hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0.
REQ-030 Back-to-back: in_valid held high, out_ready=1, q=8'd10 then 8'd99 -> bcd 12'h010 then 12'h099; second accept occurs one edge after first DONE exit.
REQ-031 Accept q=8'd128, assert rst_n=0 at the 4th SHIFT cycle -> all outputs 0 immediately, in_ready=1; next q=8'd7 -> bcd=12'h007.
REQ-032 MATH_DIVIDER_DIV0_CHECK_EN defined, y=0, q=8'hFF, r=5'd3 -> out_valid on next edge, div0=1, bcd=12'hFFF, rem=3; undefined -> bcd=12'h255, div0=0 after 9 edges.
